// File: rtl/mac_package.sv
// mac_package: TCDM bus widths, error read pattern and request/response records.
package mac_package;

    localparam int unsigned TCDM_DW  = 32;
    localparam int unsigned TCDM_AW  = 32;
    localparam int unsigned TCDM_BEW = 4;

    localparam logic [TCDM_DW-1:0] TCDM_ERR_PATTERN = 32'hDEADBEEF;

    typedef struct packed {
        logic [TCDM_AW-1:0]  add;
        logic                wen;
        logic [TCDM_BEW-1:0] be;
        logic [TCDM_DW-1:0]  data;
    } tcdm_req_t;

    typedef struct packed {
        logic [TCDM_DW-1:0] r_data;
        logic               r_valid;
    } tcdm_resp_t;

endpackage

// File: rtl/mac_tcdm_rr_arbiter.sv
// mac_tcdm_rr_arbiter: round-robin arbiter; priority starts at the pointer, which moves past each winner.
module mac_tcdm_rr_arbiter #(
    parameter int unsigned NB_PORTS = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic [NB_PORTS-1:0] req_i,
    output logic [NB_PORTS-1:0] gnt_o
);

    localparam int unsigned PW = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1;

    logic [PW-1:0] ptr_q, ptr_d, idx;

    // Scan from the farthest offset down so the request closest to the pointer wins last.
    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        idx   = '0;
        for (int i = NB_PORTS - 1; i >= 0; i--) begin
            idx = PW'((int'(ptr_q) + i) % NB_PORTS);
            if (req_i[idx]) begin
                gnt_o      = '0;
                gnt_o[idx] = 1'b1;
                ptr_d      = (idx == PW'(NB_PORTS - 1)) ? '0 : idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) ptr_q <= '0;
        else                  ptr_q <= ptr_d;
    end

endmodule

// File: rtl/mac_tcdm_responder.sv
// mac_tcdm_responder: word-interleaved banked TCDM slave with per-bank round-robin and 1-cycle responses.
// Define MAC_TCDM_RESP_STALL_EN to add LFSR-driven random grant suppression for backpressure stress.
module mac_tcdm_responder
    import mac_package::*;
#(
    parameter int unsigned NB_PORTS   = 4,
    parameter int unsigned NB_BANKS   = 8,
    parameter int unsigned BANK_WORDS = 256
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clear_i,
    input  logic [NB_PORTS-1:0]          tcdm_req_i,
    output logic [NB_PORTS-1:0]          tcdm_gnt_o,
    input  logic [NB_PORTS*TCDM_AW-1:0]  tcdm_add_i,
    input  logic [NB_PORTS-1:0]          tcdm_wen_i,
    input  logic [NB_PORTS*TCDM_BEW-1:0] tcdm_be_i,
    input  logic [NB_PORTS*TCDM_DW-1:0]  tcdm_data_i,
    output logic [NB_PORTS*TCDM_DW-1:0]  tcdm_r_data_o,
    output logic [NB_PORTS-1:0]          tcdm_r_valid_o,
    output logic                         err_o
);

    localparam int unsigned BW = $clog2(NB_BANKS);
    localparam int unsigned RW = $clog2(BANK_WORDS);
    localparam logic [TCDM_AW:0] ADDR_LIMIT = (TCDM_AW + 1)'(NB_BANKS * BANK_WORDS * 4);

    tcdm_req_t           req_s     [NB_PORTS];
    tcdm_resp_t          resp_s    [NB_PORTS];
    logic [BW-1:0]       bank_s    [NB_PORTS];
    logic [RW-1:0]       row_s     [NB_PORTS];
    logic [NB_PORTS-1:0] in_range, req_v;
    logic [NB_PORTS-1:0] bank_req  [NB_BANKS];
    logic [NB_PORTS-1:0] bank_gnt  [NB_BANKS];
    logic [TCDM_DW-1:0]  bank_rdata[NB_BANKS];

    logic [NB_PORTS-1:0] r_valid_q, r_valid_d, r_read_q, r_oor_q;
    logic [BW-1:0]       r_bank_q  [NB_PORTS];
    logic                err_q, err_d;

    always_comb begin
        for (int p = 0; p < NB_PORTS; p++) begin
            req_s[p]    = '{add:  tcdm_add_i[p*TCDM_AW +: TCDM_AW],
                            wen:  tcdm_wen_i[p],
                            be:   tcdm_be_i[p*TCDM_BEW +: TCDM_BEW],
                            data: tcdm_data_i[p*TCDM_DW +: TCDM_DW]};
            bank_s[p]   = req_s[p].add[2 +: BW];
            row_s[p]    = req_s[p].add[2+BW +: RW];
            in_range[p] = {1'b0, req_s[p].add} < ADDR_LIMIT;
        end
    end

`ifdef MAC_TCDM_RESP_STALL_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) lfsr_q <= 16'hACE1;
        else                  lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // Stalled ports are hidden from the arbiters so they cannot steal a turn.
    assign req_v = tcdm_req_i & ~lfsr_q[NB_PORTS-1:0];
`else
    assign req_v = tcdm_req_i;
`endif

    always_comb begin
        for (int b = 0; b < NB_BANKS; b++)
            for (int p = 0; p < NB_PORTS; p++)
                bank_req[b][p] = req_v[p] && (bank_s[p] == BW'(b));
    end

    always_comb begin
        tcdm_gnt_o = '0;
        for (int p = 0; p < NB_PORTS; p++)
            tcdm_gnt_o[p] = bank_gnt[bank_s[p]][p];
    end

    for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
        logic [TCDM_DW-1:0]  mem_q [BANK_WORDS];
        logic [TCDM_DW-1:0]  rdata_q;
        logic                we;
        logic [RW-1:0]       row;
        logic [TCDM_DW-1:0]  wdata;
        logic [TCDM_BEW-1:0] be;

        mac_tcdm_rr_arbiter #(.NB_PORTS(NB_PORTS)) i_arb (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .clear_i (clear_i),
            .req_i   (bank_req[b]),
            .gnt_o   (bank_gnt[b])
        );

        // Out-of-range writes and writes on a reset/clear cycle never reach the array.
        always_comb begin
            we    = 1'b0;
            row   = '0;
            wdata = '0;
            be    = '0;
            for (int p = 0; p < NB_PORTS; p++) begin
                if (bank_gnt[b][p]) begin
                    we    = !req_s[p].wen && in_range[p] && !rst_i && !clear_i;
                    row   = row_s[p];
                    wdata = req_s[p].data;
                    be    = req_s[p].be;
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (we)
                for (int j = 0; j < TCDM_BEW; j++)
                    if (be[j]) mem_q[row][8*j +: 8] <= wdata[8*j +: 8];
            rdata_q <= mem_q[row];
        end

        assign bank_rdata[b] = rdata_q;
    end

    always_comb begin
        r_valid_d = (rst_i || clear_i) ? '0 : tcdm_gnt_o;
        err_d     = (rst_i || clear_i) ? 1'b0 : err_q | (|(tcdm_gnt_o & ~in_range));
    end

    always_ff @(posedge clk_i) begin
        r_valid_q <= r_valid_d;
        err_q     <= err_d;
        r_read_q  <= tcdm_wen_i;
        r_oor_q   <= ~in_range;
        for (int p = 0; p < NB_PORTS; p++)
            r_bank_q[p] <= bank_s[p];
    end

    always_comb begin
        tcdm_r_data_o  = '0;
        tcdm_r_valid_o = '0;
        for (int p = 0; p < NB_PORTS; p++) begin
            resp_s[p].r_valid = r_valid_q[p];
            resp_s[p].r_data  = (!r_valid_q[p] || !r_read_q[p]) ? '0 :
                                r_oor_q[p] ? TCDM_ERR_PATTERN : bank_rdata[r_bank_q[p]];
            tcdm_r_data_o[p*TCDM_DW +: TCDM_DW] = resp_s[p].r_data;
            tcdm_r_valid_o[p]                   = resp_s[p].r_valid;
        end
    end

    assign err_o = err_q;

endmodule
